// File: rtl/bcd_to_binary_if.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_if
// Request/result bundle for the BCD-to-binary converter.
//   valid        : request strobe (master -> slave)
//   BCD_code     : packed BCD magnitude, digit 0 in bits [3:0]
//   sign         : 1 = negative
//   busy         : conversion in progress (slave -> master)
//   binary_ready : one-cycle pulse, binary/error just updated
//   binary       : signed two's-complement result
//   error        : last request held a nibble > 9
// ---------------------------------------------------------------------------
interface bcd_to_binary_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 16
) ();

   logic                  valid;
   logic [4*DIGITS-1:0]   BCD_code;
   logic                  sign;
   logic                  busy;
   logic                  binary_ready;
   logic [BIN_W-1:0]      binary;
   logic                  error;

   modport master (
      output valid, BCD_code, sign,
      input  busy, binary_ready, binary, error
   );

   modport slave (
      input  valid, BCD_code, sign,
      output busy, binary_ready, binary, error
   );

endinterface

// File: rtl/bcd_to_binary.sv
// ---------------------------------------------------------------------------
// bcd_to_binary
// Converts a packed, sign-magnitude BCD number into a two's-complement
// binary value using reverse double-dabble (one bit per clock).
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : bcd_to_binary_if.slave
//              in : valid, BCD_code, sign
//              out: busy, binary_ready, binary, error
//
// Flow: IDLE accepts a request and screens every nibble. A non-BCD nibble
// goes straight to DONE flagged invalid; otherwise 4*DIGITS SHIFT cycles
// run, then DONE registers the result and pulses binary_ready.
// binary/error hold until the next DONE.
// ---------------------------------------------------------------------------
module bcd_to_binary #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 16
) (
   input  logic            clk,
   input  logic            reset,
   bcd_to_binary_if.slave  bus
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = (BCD_W > 1) ? $clog2(BCD_W) : 1;
   localparam int unsigned EXT_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCD_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 r_state;
   logic [2*BCD_W-1:0]     r_shift;    // {BCD field, binary field}
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_sign;
   logic                   r_invalid;
   logic                   r_busy;
   logic                   r_ready;
   logic [BIN_W-1:0]       r_binary;
   logic                   r_error;

   logic                   w_code_bad;
   logic [2*BCD_W-1:0]     w_shifted;
   logic [2*BCD_W-1:0]     w_shift_adj;
   logic [EXT_W-1:0]       w_mag_ext;
   logic [BIN_W-1:0]       w_mag;
   logic [BIN_W-1:0]       w_result;

   // Any nibble above 9 makes the whole request invalid.
   always_comb begin
      w_code_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bus.BCD_code[4*i +: 4] > 4'd9) begin
            w_code_bad = 1'b1;
         end
      end
   end

   // One reverse double-dabble step: shift right, then pull 3 out of each
   // BCD nibble that landed at 8 or above (undoes the x2 weight of the
   // bit that crossed a nibble boundary).
   always_comb begin
      w_shifted   = r_shift >> 1;
      w_shift_adj = w_shifted;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (w_shifted[BCD_W + 4*i +: 4] >= 4'd8) begin
            w_shift_adj[BCD_W + 4*i +: 4] = w_shifted[BCD_W + 4*i +: 4] - 4'd3;
         end
      end
   end

   // Magnitude is fitted to BIN_W; negation of zero stays zero.
   always_comb begin
      w_mag_ext = EXT_W'(r_shift[BCD_W-1:0]);
      w_mag     = w_mag_ext[BIN_W-1:0];
      w_result  = r_sign ? (~w_mag + 1'b1) : w_mag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_sign    <= 1'b0;
         r_invalid <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_binary  <= '0;
         r_error   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.valid) begin
                  r_sign <= bus.sign;
                  r_busy <= 1'b1;
                  if (w_code_bad) begin
                     r_invalid <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_invalid <= 1'b0;
                     r_shift   <= {bus.BCD_code, {BCD_W{1'b0}}};
                     r_cnt     <= '0;
                     r_state   <= SHIFT;
                  end
               end
            end

            SHIFT: begin
               r_shift <= w_shift_adj;
               if (r_cnt == CNT_LAST) begin
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            DONE: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
               if (r_invalid) begin
                  r_binary <= '0;
                  r_error  <= 1'b1;
               end else begin
                  r_binary <= w_result;
                  r_error  <= 1'b0;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = r_busy;
   assign bus.binary_ready = r_ready;
   assign bus.binary       = r_binary;
   assign bus.error        = r_error;

endmodule
